// File: rtl/output_judge.sv
`default_nettype none
// ============================================================================
//  Module      : output_judge
//  Description : Turns a class label into a one-hot teacher vector, finds the
//                argmax of the output-layer activations with a one-lane-per-
//                cycle scan, and reports hit/predicted class with running
//                hit and sample counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_judge #(
    parameter int NP        = 7,
    parameter int NC        = 6,
    parameter int WF        = 5,
    parameter int TRUE_VAL  = 2**(WF-1),
    parameter int FALSE_VAL = 0,
    parameter int WC        = 16,
    localparam int c_WO     = $clog2(NP) + WF,
    localparam int c_WL     = $clog2(NC)
) (
    input  logic                 iCLK,
    input  logic                 iRST,
    input  logic                 iMode,
    input  logic                 iClear,
    input  logic                 iValid_AS_Label,
    output logic                 oReady_AS_Label,
    input  logic [c_WL-1:0]      iData_AS_Label,
    output logic                 oValid_BM_Teacher,
    input  logic                 iReady_BM_Teacher,
    output logic [NC*c_WO-1:0]   oData_BM_Teacher,
    input  logic                 iValid_AM_Output,
    output logic                 oReady_AM_Output,
    input  logic [NC*c_WO-1:0]   iData_AM_Output,
    output logic                 oValid_BM_Result,
    input  logic                 iReady_BM_Result,
    output logic [c_WL:0]        oData_BM_Result,
    output logic [WC-1:0]        oCount_Hit,
    output logic [WC-1:0]        oCount_Sample
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SCAN   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [c_WO-1:0] c_TRUE   = c_WO'(TRUE_VAL);
    localparam logic [c_WO-1:0] c_FALSE  = c_WO'(FALSE_VAL);
    localparam logic [c_WL-1:0] c_LAST   = c_WL'(NC - 1);
    localparam logic [c_WL:0]   c_NCLIM  = (c_WL + 1)'(NC);

    state_t                  r_state, w_nextState;
    logic                    r_labelReady, r_outReady, r_teachValid, r_teachDone;
    logic                    r_captured, r_resValid;
    logic [c_WL-1:0]         r_label, r_lane, r_idx, w_idxNext;
    logic [NC*c_WO-1:0]      r_vec, r_teacher, w_teacherNext;
    logic signed [c_WO-1:0]  r_best, w_bestNext;
    logic [c_WO-1:0]         w_lanes [NC];
    logic [c_WL:0]           r_result;
    logic [WC-1:0]           r_countHit, r_countSample;
    logic                    w_hit, w_capturedNext;
    logic                    w_labelFire, w_teachFire, w_outFire, w_resFire;

    assign w_labelFire = r_labelReady & iValid_AS_Label;
    assign w_teachFire = r_teachValid & iReady_BM_Teacher;
    assign w_outFire   = r_outReady   & iValid_AM_Output;
    assign w_resFire   = r_resValid   & iReady_BM_Result;

    // Lane views of the captured vector and the one-hot teacher for the
    // incoming label (an out-of-range label matches no lane).
    for (genvar i = 0; i < NC; i++) begin : g_lanes
        assign w_lanes[i] = r_vec[i*c_WO +: c_WO];
        assign w_teacherNext[i*c_WO +: c_WO] =
            (iData_AS_Label == c_WL'(i)) ? c_TRUE : c_FALSE;
    end

    // Scan step: lane 0 seeds the best, later lanes replace it only when strictly greater
    always_comb begin
        w_bestNext = r_best;
        w_idxNext  = r_idx;
        if (r_lane == '0) begin
            w_bestNext = $signed(w_lanes[r_lane]);
            w_idxNext  = '0;
        end else if ($signed(w_lanes[r_lane]) > r_best) begin
            w_bestNext = $signed(w_lanes[r_lane]);
            w_idxNext  = r_lane;
        end
        w_hit = (w_idxNext == r_label) && ({1'b0, r_label} < c_NCLIM);
    end

    // Next-state logic; the teacher and output channels progress independently in WAIT
    always_comb begin
        w_nextState    = r_state;
        w_capturedNext = w_labelFire ? 1'b0 : (r_captured | w_outFire);
        case (r_state)
            S_IDLE:   if (w_labelFire) w_nextState = S_WAIT;
            S_WAIT:   if ((r_captured | w_outFire) && (r_teachDone | w_teachFire))
                          w_nextState = S_SCAN;
            S_SCAN:   if (r_lane == c_LAST) w_nextState = S_RESULT;
            S_RESULT: if (w_resFire) w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    // Datapath, registered handshake flags and counters
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_labelReady  <= 1'b0;
            r_outReady    <= 1'b0;
            r_teachValid  <= 1'b0;
            r_teachDone   <= 1'b0;
            r_captured    <= 1'b0;
            r_resValid    <= 1'b0;
            r_label       <= '0;
            r_lane        <= '0;
            r_idx         <= '0;
            r_best        <= '0;
            r_vec         <= '0;
            r_teacher     <= '0;
            r_result      <= '0;
            r_countHit    <= '0;
            r_countSample <= '0;
        end else begin
            r_labelReady <= (w_nextState == S_IDLE);
            r_outReady   <= (w_nextState == S_WAIT) && !w_capturedNext;
            r_captured   <= w_capturedNext;
            if (w_outFire) r_vec <= iData_AM_Output;

            if (w_labelFire) begin
                r_label      <= iData_AS_Label;
                r_teacher    <= w_teacherNext;
                r_teachValid <= iMode;
                r_teachDone  <= !iMode;
            end else if (w_teachFire) begin
                r_teachValid <= 1'b0;
                r_teachDone  <= 1'b1;
            end

            if (r_state == S_SCAN) begin
                r_best <= w_bestNext;
                r_idx  <= w_idxNext;
                if (r_lane != c_LAST) r_lane <= r_lane + c_WL'(1);
            end else begin
                r_lane <= '0;
            end

            if (r_state == S_SCAN && w_nextState == S_RESULT) begin
                r_resValid <= 1'b1;
                r_result   <= {w_hit, w_idxNext};
            end else if (w_resFire) begin
                r_resValid <= 1'b0;
            end

            // A coincident clear takes priority over counting a delivered result
            if (iClear) begin
                r_countHit    <= '0;
                r_countSample <= '0;
            end else if (w_resFire) begin
                r_countSample <= r_countSample + WC'(1);
                r_countHit    <= r_countHit + WC'(r_result[c_WL]);
            end
        end
    end

    assign oReady_AS_Label   = r_labelReady;
    assign oReady_AM_Output  = r_outReady;
    assign oValid_BM_Teacher = r_teachValid;
    assign oData_BM_Teacher  = r_teacher;
    assign oValid_BM_Result  = r_resValid;
    assign oData_BM_Result   = r_result;
    assign oCount_Hit        = r_countHit;
    assign oCount_Sample     = r_countSample;

endmodule
`default_nettype wire

// File: tb/tb_output_judge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_judge
//  Description : Table-driven self-checking bench for output_judge with a
//                result/teacher scoreboard and hand-written corner sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic        iMode, iClear;
    logic        iValid_AS_Label, oReady_AS_Label;
    logic [2:0]  iData_AS_Label;
    logic        oValid_BM_Teacher, iReady_BM_Teacher;
    logic [47:0] oData_BM_Teacher;
    logic        iValid_AM_Output, oReady_AM_Output;
    logic [47:0] iData_AM_Output;
    logic        oValid_BM_Result, iReady_BM_Result;
    logic [3:0]  oData_BM_Result;
    logic [15:0] oCount_Hit, oCount_Sample;

    output_judge dut (
        .iCLK              (clk),
        .iRST              (rst),
        .iMode             (iMode),
        .iClear            (iClear),
        .iValid_AS_Label   (iValid_AS_Label),
        .oReady_AS_Label   (oReady_AS_Label),
        .iData_AS_Label    (iData_AS_Label),
        .oValid_BM_Teacher (oValid_BM_Teacher),
        .iReady_BM_Teacher (iReady_BM_Teacher),
        .oData_BM_Teacher  (oData_BM_Teacher),
        .iValid_AM_Output  (iValid_AM_Output),
        .oReady_AM_Output  (oReady_AM_Output),
        .iData_AM_Output   (iData_AM_Output),
        .oValid_BM_Result  (oValid_BM_Result),
        .iReady_BM_Result  (iReady_BM_Result),
        .oData_BM_Result   (oData_BM_Result),
        .oCount_Hit        (oCount_Hit),
        .oCount_Sample     (oCount_Sample)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [2:0]  label;
        logic [47:0] vec;
        int          tDly;
        int          rDly;
        logic        clr;
        logic [3:0]  exp;   // {hit, predicted}
    } vec_t;

    vec_t        vt [11];
    logic [3:0]  resQ [$];
    logic [47:0] teachQ [$];
    int          nTests = 0;
    int          nFail  = 0;
    int          expHit = 0;
    int          expSamp = 0;

    function automatic logic [47:0] mk(input int l0, l1, l2, l3, l4, l5);
        int          a [6];
        logic [47:0] v;
        a = '{l0, l1, l2, l3, l4, l5};
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = a[i][7:0];
        return v;
    endfunction

    function automatic logic [47:0] teach_of(input logic [2:0] lbl);
        logic [47:0] v;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = (int'(lbl) == i) ? 8'd16 : 8'd0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return oReady_AS_Label;
            default: return oReady_AM_Output;
        endcase
    endfunction

    task automatic wait_fire(input int which, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (sel(which)) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            nTests++;
            nFail++;
            $display("FAIL %s: no handshake within 200 cycles", name);
        end
    endtask

    // Scoreboard consumer: compares every delivered result and teacher vector
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (oValid_BM_Result && iReady_BM_Result) begin
                    if (resQ.size() == 0) check("result_unexpected", 64'(oValid_BM_Result), 64'(0));
                    else check("result_data", 64'(oData_BM_Result), 64'(resQ.pop_front()));
                end
                if (oValid_BM_Teacher) begin
                    if (teachQ.size() == 0) check("teacher_unexpected", 64'(oValid_BM_Teacher), 64'(0));
                    else if (iReady_BM_Teacher)
                        check("teacher_data", 64'(oData_BM_Teacher), 64'(teachQ.pop_front()));
                end
            end
        end
    endtask

    task automatic run(input vec_t v);
        int         lat;
        logic [3:0] r0;
        resQ.push_back(v.exp);
        if (v.mode) teachQ.push_back(teach_of(v.label));
        iValid_AS_Label = 1'b1; iData_AS_Label = v.label; iMode = v.mode;
        wait_fire(0, "label_accept");
        // mode/label changes after acceptance must be ignored
        iValid_AS_Label = 1'b0; iData_AS_Label = ~v.label; iMode = ~v.mode;
        iValid_AM_Output = 1'b1; iData_AM_Output = v.vec;
        if (v.mode && v.tDly == 0) iReady_BM_Teacher = 1'b1;
        wait_fire(1, "output_capture");
        iValid_AM_Output = 1'b0; iData_AM_Output = '0; iReady_BM_Teacher = 1'b0;
        if (v.mode && v.tDly > 0) begin
            repeat (v.tDly) @(posedge clk);
            #1;
            check("teacher_held", 64'(oValid_BM_Teacher), 64'(1));
            check("no_scan_before_teacher", 64'(oValid_BM_Result), 64'(0));
            iReady_BM_Teacher = 1'b1;
            @(posedge clk); #1;
            iReady_BM_Teacher = 1'b0;
        end
        lat = 0;
        while (!oValid_BM_Result && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("result_latency", 64'(lat), 64'(6));
        r0 = oData_BM_Result;
        if (v.rDly > 0) begin
            repeat (v.rDly) @(posedge clk);
            #1;
            check("result_stable", 64'({oValid_BM_Result, oData_BM_Result}), 64'({1'b1, r0}));
        end
        check("label_ready_low", 64'(oReady_AS_Label), 64'(0));
        iReady_BM_Result = 1'b1; iClear = v.clr;
        @(posedge clk); #1;
        iReady_BM_Result = 1'b0; iClear = 1'b0;
        if (v.clr) begin
            expHit = 0; expSamp = 0;
        end else begin
            expSamp++;
            expHit += int'(v.exp[3]);
        end
        check("count_hit", 64'(oCount_Hit), 64'(expHit));
        check("count_sample", 64'(oCount_Sample), 64'(expSamp));
        check("result_drop", 64'(oValid_BM_Result), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b0, 3'd3, mk(5, -2, 9, 40, 1, 7),          0,  0, 1'b0, 4'b1011};
        vt[1]  = '{1'b1, 3'd2, mk(3, 30, -1, 2, 0, 4),          8,  0, 1'b0, 4'b0001};
        vt[2]  = '{1'b0, 3'd0, mk(-4, -4, -4, -4, -4, -4),      0,  0, 1'b0, 4'b1000};
        vt[3]  = '{1'b0, 3'd5, mk(0, 0, 0, 0, 20, 20),          0,  0, 1'b0, 4'b0100};
        vt[4]  = '{1'b1, 3'd7, mk(1, 2, 3, 4, 5, 127),          0,  0, 1'b0, 4'b0101};
        vt[5]  = '{1'b1, 3'd1, mk(-10, -3, -128, -3, -50, -7),  3,  0, 1'b0, 4'b1001};
        vt[6]  = '{1'b0, 3'd1, mk(0, 50, -50, 49, 0, 0),        0, 10, 1'b0, 4'b1001};
        vt[7]  = '{1'b1, 3'd1, mk(60, 59, 0, 0, 0, 0),          2, 10, 1'b0, 4'b0000};
        vt[8]  = '{1'b0, 3'd4, mk(-1, -1, -1, -1, 127, -128),   0, 10, 1'b0, 4'b1100};
        vt[9]  = '{1'b0, 3'd2, mk(0, 0, 9, 0, 0, 0),            0,  0, 1'b1, 4'b1010};
        vt[10] = '{1'b1, 3'd5, mk(-7, -6, -5, -4, -3, -2),      1,  0, 1'b0, 4'b1101};

        rst = 1'b1; iMode = 1'b0; iClear = 1'b0;
        iValid_AS_Label = 1'b0; iData_AS_Label = '0;
        iReady_BM_Teacher = 1'b0; iValid_AM_Output = 1'b0; iData_AM_Output = '0;
        iReady_BM_Result = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_label_ready", 64'(oReady_AS_Label), 64'(0));
        check("rst_out_ready", 64'(oReady_AM_Output), 64'(0));
        check("rst_teacher", 64'({oValid_BM_Teacher, oData_BM_Teacher}), 64'(0));
        check("rst_result", 64'({oValid_BM_Result, oData_BM_Result}), 64'(0));
        check("rst_counts", 64'({oCount_Hit, oCount_Sample}), 64'(0));
        rst = 1'b0;
        fork
            monitor();
        join_none

        for (int i = 0; i < 11; i++) begin
            if (i == 6) begin
                // standalone clear in IDLE
                iClear = 1'b1;
                @(posedge clk); #1;
                iClear = 1'b0;
                expHit = 0; expSamp = 0;
                check("clear_counts", 64'({oCount_Hit, oCount_Sample}), 64'(0));
            end
            if (i == 9) begin
                // asynchronous reset in the middle of a scan
                check("pre_reset_counts", 64'({oCount_Hit, oCount_Sample}), 64'({16'd2, 16'd3}));
                iValid_AS_Label = 1'b1; iData_AS_Label = 3'd0; iMode = 1'b0;
                wait_fire(0, "rst_label_accept");
                iValid_AS_Label = 1'b0;
                iValid_AM_Output = 1'b1; iData_AM_Output = mk(1, 2, 3, 4, 5, 6);
                wait_fire(1, "rst_output_capture");
                iValid_AM_Output = 1'b0;
                repeat (3) @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                check("async_rst_valids", 64'({oValid_BM_Result, oValid_BM_Teacher}), 64'(0));
                check("async_rst_readies", 64'({oReady_AS_Label, oReady_AM_Output}), 64'(0));
                check("async_rst_counts", 64'({oCount_Hit, oCount_Sample}), 64'(0));
                check("async_rst_result", 64'(oData_BM_Result), 64'(0));
                #1;
                rst = 1'b0;
                resQ.delete(); teachQ.delete();
                expHit = 0; expSamp = 0;
                @(posedge clk); #1;
            end
            run(vt[i]);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_queues_empty", 64'(resQ.size() + teachQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
